rv_wb_arbiter: RTL

- N-port Wishbone B4 classic master arbiter: the next-generation replacement for the fixed two-port instruction/data mux at the core top level.
- Merges N_PORTS independent requesters (fetch, load/store, debug, DMA) onto one Wishbone bus.
- Selection is fixed-priority or round-robin; the winner's request is latched, and STB/CYC are driven only while a transaction is open.
- Optional bus-timeout watchdog returns an error to the requester.

---
 rtl/rv_wb_pkg.sv | 23 ++
 rtl/rv_rr_select.sv | 40 ++++
 rtl/rv_wb_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv_wb_pkg.sv
`default_nettype none
// ============================================================================
// rv_wb_pkg : shared types and helpers for the Wishbone master arbiter
// Revision  : 1.0
// ============================================================================
package rv_wb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } wb_arb_state_t;

  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_rr_select.sv
`default_nettype none
// ============================================================================
// rv_rr_select : combinational fixed-priority / round-robin request picker
// Revision     : 1.0
// ============================================================================
module rv_rr_select
  import rv_wb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   base,
  input  arb_mode_t          mode,
  output logic [N_PORTS-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  // Round-robin searches upward from the slot after the last winner.
  always_comb begin
    int   start;
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    start = (mode == ARB_RR) ? (int'(base) + 1) % N_PORTS : 0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = (start + k) % N_PORTS;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PTR_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rv_wb_arbiter : N-port Wishbone B4 classic master arbiter with watchdog
// Revision      : 1.0
// ============================================================================
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int N_PORTS        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [N_PORTS-1:0]              i_req,
  input  logic [N_PORTS*ADDR_W-1:0]       i_addr,
  input  logic [N_PORTS*DATA_W-1:0]       i_wdata,
  input  logic [N_PORTS-1:0]              i_we,
  input  logic [N_PORTS*sel_w(DATA_W)-1:0] i_sel,
  output logic [N_PORTS-1:0]              o_ack,
  output logic [N_PORTS-1:0]              o_err,
  output logic [DATA_W-1:0]               o_rdata,
  output logic [N_PORTS-1:0]              o_grant,
  output logic [ADDR_W-1:0]               o_wb_adr,
  output logic [DATA_W-1:0]               o_wb_dat,
  output logic                            o_wb_we,
  output logic [sel_w(DATA_W)-1:0]        o_wb_sel,
  output logic                            o_wb_stb,
  output logic                            o_wb_cyc,
  input  logic [DATA_W-1:0]               i_wb_dat,
  input  logic                            i_wb_ack,
  input  logic                            i_wb_err
);

  localparam int        SEL_W = sel_w(DATA_W);
  localparam int        PTR_W = $clog2(N_PORTS);
  localparam arb_mode_t MODE  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  wb_arb_state_t      state, state_nxt;
  logic [N_PORTS-1:0] grant_q, pick_oh;
  logic [PTR_W-1:0]   ptr_q, pick_idx;
  logic [ADDR_W-1:0]  adr_q, pick_adr;
  logic [DATA_W-1:0]  dat_q, pick_dat;
  logic [SEL_W-1:0]   sel_q, pick_sel;
  logic               we_q, pick_we;
  logic               tmo_hit;

  rv_rr_select #(
    .N_PORTS(N_PORTS),
    .PTR_W  (PTR_W)
  ) u_select (
    .req  (i_req),
    .base (ptr_q),
    .mode (MODE),
    .grant(pick_oh),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_adr = '0;
    pick_dat = '0;
    pick_sel = '0;
    pick_we  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick_oh[i]) begin
        pick_adr = i_addr[i*ADDR_W +: ADDR_W];
        pick_dat = i_wdata[i*DATA_W +: DATA_W];
        pick_sel = i_sel[i*SEL_W +: SEL_W];
        pick_we  = i_we[i];
      end
    end
  end

  // Counter idles at zero so it starts fresh on every BUSY entry.
  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)             cnt_q <= '0;
      else if (state == ST_IDLE)  cnt_q <= '0;
      else                        cnt_q <= cnt_q + 1'b1;
    end
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(N_PORTS - 1);
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && |i_req) begin
        grant_q <= pick_oh;
        ptr_q   <= pick_idx;
        adr_q   <= pick_adr;
        dat_q   <= pick_dat;
        sel_q   <= pick_sel;
        we_q    <= pick_we;
      end
    end
  end

  // err dominates ack; ack dominates a coincident timeout.
  always_comb begin
    state_nxt = state;
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_grant   = '0;
    o_ack     = '0;
    o_err     = '0;
    case (state)
      ST_IDLE: begin
        if (|i_req) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = we_q;
        o_grant  = grant_q;
        if (i_wb_err || (tmo_hit && !i_wb_ack)) begin
          o_err     = grant_q;
          state_nxt = ST_IDLE;
        end else if (i_wb_ack) begin
          o_ack     = grant_q;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_wb_adr = adr_q;
  assign o_wb_dat = dat_q;
  assign o_wb_sel = sel_q;
  assign o_rdata  = i_wb_dat;

endmodule
`default_nettype wire
